// File: rtl/common.sv
// Shared limits used across pipeline blocks.
package common;

  localparam int WB_MAX_CH = 8;

endpackage

// File: rtl/pipes.sv
// Record types passed between MIPS pipeline stages.
package pipes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        reg_write;
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty; clr empties it in one edge.
module wb_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T            mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: per-channel result FIFOs, one grant per cycle (fixed or round-robin), registered output.
module writeback_arbiter
  import pipes::*;
  import common::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 2,
  parameter int RR_MODE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         in_valid,
  input  wb_req_t [NUM_CH-1:0]      in_req,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      wb_valid,
  output wb_req_t                   wb_req,
  output logic [$clog2(NUM_CH)-1:0] wb_ch,
  output logic [31:0]               retire_cnt
);

  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > WB_MAX_CH) begin : g_bad_num_ch
    $error("writeback_arbiter: NUM_CH out of range");
  end

  wb_req_t           head [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   rr_ptr;
  logic              grant_vld_p0;
  logic [CH_W-1:0]   grant_idx_p0;
  logic [CH_W-1:0]   rr_next_p0;

  // In fixed mode the scan starts at channel 0; in RR mode at rr_ptr, wrapping.
  function automatic logic [CH_W-1:0] scan_idx(input int k, input logic [CH_W-1:0] base);
    int idx;
    idx = (RR_MODE != 0) ? (int'(base) + k) % NUM_CH : k;
    return CH_W'(idx);
  endfunction

  assign in_ready = ~full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign pop[c] = grant_vld_p0 && (grant_idx_p0 == CH_W'(c)) && !stall && !flush;

    wb_fifo #(
      .DEPTH (DEPTH),
      .T     (wb_req_t)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .push  (in_valid[c]),
      .pop   (pop[c]),
      .din   (in_req[c]),
      .head  (head[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  // Stage p0: arbitration over FIFO heads (downward scan so the earliest in scan order wins)
  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!empty[scan_idx(k, rr_ptr)]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = scan_idx(k, rr_ptr);
      end
    end
  end

  assign rr_next_p0 = (grant_idx_p0 == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_p0 + 1'b1;

  // Stage p1: output register, retire counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_req     <= '0;
      wb_ch      <= '0;
      retire_cnt <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_req   <= '0;
    end else if (!stall) begin
      if (grant_vld_p0) begin
        wb_valid   <= 1'b1;
        wb_req     <= head[grant_idx_p0];
        wb_ch      <= grant_idx_p0;
        retire_cnt <= retire_cnt + 32'd1;
        if (RR_MODE != 0) rr_ptr <= rr_next_p0;
      end else begin
        wb_valid <= 1'b0;
        wb_req   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench: one fixed-priority (2 ch) and one round-robin (3 ch) instance of the writeback arbiter.
module tb_writeback_arbiter;
  import pipes::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]      fx_in_valid;
  wb_req_t [1:0]   fx_in_req;
  logic [1:0]      fx_in_ready;
  logic            fx_stall, fx_flush, fx_wb_valid;
  wb_req_t         fx_wb_req;
  logic [0:0]      fx_wb_ch;
  logic [31:0]     fx_retire;

  logic [2:0]      rr_in_valid;
  wb_req_t [2:0]   rr_in_req;
  logic [2:0]      rr_in_ready;
  logic            rr_stall, rr_flush, rr_wb_valid;
  wb_req_t         rr_wb_req;
  logic [1:0]      rr_wb_ch;
  logic [31:0]     rr_retire;

  int tests = 0;
  int fails = 0;

  writeback_arbiter #(.NUM_CH(2), .DEPTH(2), .RR_MODE(0)) dut_fx (
    .clk(clk), .reset(reset), .in_valid(fx_in_valid), .in_req(fx_in_req), .in_ready(fx_in_ready),
    .stall(fx_stall), .flush(fx_flush), .wb_valid(fx_wb_valid), .wb_req(fx_wb_req),
    .wb_ch(fx_wb_ch), .retire_cnt(fx_retire)
  );

  writeback_arbiter #(.NUM_CH(3), .DEPTH(2), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(rr_in_valid), .in_req(rr_in_req), .in_ready(rr_in_ready),
    .stall(rr_stall), .flush(rr_flush), .wb_valid(rr_wb_valid), .wb_req(rr_wb_req),
    .wb_ch(rr_wb_ch), .retire_cnt(rr_retire)
  );

  function automatic wb_req_t mk(input logic [31:0] pc, input logic [4:0] dst, input logic [31:0] data);
    wb_req_t r;
    r = '0;
    r.pc          = pc;
    r.instruction = 32'h0043_0820;
    r.reg_write   = 1'b1;
    r.dst         = dst;
    r.data        = data;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    tests++; if (fx_wb_valid !== 1'b0) begin fails++; $display("FAIL rst_fx_valid got %b want 0", fx_wb_valid); end
    tests++; if (fx_wb_req !== '0) begin fails++; $display("FAIL rst_fx_req got %h want 0", fx_wb_req); end
    tests++; if (fx_wb_ch !== 1'b0) begin fails++; $display("FAIL rst_fx_ch got %0d want 0", fx_wb_ch); end
    tests++; if (fx_retire !== 32'd0) begin fails++; $display("FAIL rst_fx_retire got %0d want 0", fx_retire); end
    tests++; if (fx_in_ready !== 2'b11) begin fails++; $display("FAIL rst_fx_ready got %b want 11", fx_in_ready); end
    tests++; if (rr_in_ready !== 3'b111) begin fails++; $display("FAIL rst_rr_ready got %b want 111", rr_in_ready); end
    tests++; if (rr_wb_valid !== 1'b0 || rr_retire !== 32'd0) begin
      fails++; $display("FAIL rst_rr_out got valid=%b retire=%0d want 0/0", rr_wb_valid, rr_retire);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency;
    fx_in_valid  = 2'b01;
    fx_in_req[0] = mk(32'h100, 5'd3, 32'hDEAD);
    tick();
    fx_in_valid = 2'b00;
    tests++; if (fx_wb_valid !== 1'b0) begin fails++; $display("FAIL lat_early got %b want 0", fx_wb_valid); end
    tick();
    tests++; if (fx_wb_valid !== 1'b1) begin fails++; $display("FAIL lat_valid got %b want 1", fx_wb_valid); end
    tests++; if (fx_wb_ch !== 1'b0) begin fails++; $display("FAIL lat_ch got %0d want 0", fx_wb_ch); end
    tests++; if (fx_wb_req.data !== 32'hDEAD || fx_wb_req.pc !== 32'h100 || fx_wb_req.dst !== 5'd3) begin
      fails++; $display("FAIL lat_req got pc=%h dst=%0d data=%h want 100/3/dead", fx_wb_req.pc, fx_wb_req.dst, fx_wb_req.data);
    end
    tests++; if (fx_retire !== 32'd1) begin fails++; $display("FAIL lat_retire got %0d want 1", fx_retire); end
    tick();
    tests++; if (fx_wb_valid !== 1'b0 || fx_wb_req !== '0) begin
      fails++; $display("FAIL lat_idle got valid=%b req=%h want 0/0", fx_wb_valid, fx_wb_req);
    end
  endtask

  task automatic test_fixed_priority;
    logic [0:0]  exp_ch   [6];
    logic [31:0] exp_data [6];
    exp_ch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_data = '{32'hA001, 32'hA002, 32'hA003, 32'hA004, 32'hB001, 32'hB002};
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc <= 4) begin
        fx_in_valid  = 2'b11;
        fx_in_req[0] = mk(32'h200 + 32'(cyc * 4), 5'd5, 32'hA000 + 32'(cyc));
        fx_in_req[1] = mk(32'h300 + 32'(cyc * 4), 5'd6, 32'hB000 + 32'(cyc));
      end else begin
        fx_in_valid = 2'b00;
      end
      tick();
      if (cyc == 1) begin
        tests++; if (fx_in_ready !== 2'b11) begin fails++; $display("FAIL prio_ready1 got %b want 11", fx_in_ready); end
        tests++; if (fx_wb_valid !== 1'b0) begin fails++; $display("FAIL prio_valid1 got %b want 0", fx_wb_valid); end
      end
      if (cyc == 2 || cyc == 3) begin
        tests++; if (fx_in_ready[1] !== 1'b0) begin fails++; $display("FAIL prio_ready_ch1 cyc%0d got %b want 0", cyc, fx_in_ready[1]); end
      end
      if (cyc >= 2 && cyc <= 7) begin
        tests++;
        if (fx_wb_valid !== 1'b1 || fx_wb_ch !== exp_ch[cyc-2] || fx_wb_req.data !== exp_data[cyc-2]) begin
          fails++;
          $display("FAIL prio_seq cyc%0d got v=%b ch=%0d data=%h want 1/%0d/%h",
                   cyc, fx_wb_valid, fx_wb_ch, fx_wb_req.data, exp_ch[cyc-2], exp_data[cyc-2]);
        end
      end
      if (cyc == 8) begin
        tests++; if (fx_wb_valid !== 1'b0) begin fails++; $display("FAIL prio_drained got %b want 0", fx_wb_valid); end
      end
    end
    tests++; if (fx_retire !== 32'd7) begin fails++; $display("FAIL prio_retire got %0d want 7", fx_retire); end
  endtask

  task automatic test_stall;
    fx_in_valid  = 2'b10;
    fx_in_req[1] = mk(32'h400, 5'd7, 32'hC001);
    tick();
    fx_in_req[1] = mk(32'h404, 5'd7, 32'hC002);
    tick();
    tests++; if (fx_wb_ch !== 1'b1 || fx_wb_req.data !== 32'hC001 || fx_retire !== 32'd8) begin
      fails++; $display("FAIL stall_pre got ch=%0d data=%h retire=%0d want 1/c001/8", fx_wb_ch, fx_wb_req.data, fx_retire);
    end
    fx_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        fx_in_valid  = 2'b01;
        fx_in_req[0] = mk(32'h500, 5'd8, 32'hD001);
      end else begin
        fx_in_valid = 2'b00;
      end
      tick();
      tests++;
      if (fx_wb_valid !== 1'b1 || fx_wb_ch !== 1'b1 || fx_wb_req.data !== 32'hC001 || fx_retire !== 32'd8) begin
        fails++;
        $display("FAIL stall_hold%0d got v=%b ch=%0d data=%h retire=%0d want 1/1/c001/8",
                 i, fx_wb_valid, fx_wb_ch, fx_wb_req.data, fx_retire);
      end
    end
    fx_stall    = 1'b0;
    fx_in_valid = 2'b00;
    tick();
    tests++; if (fx_wb_ch !== 1'b0 || fx_wb_req.data !== 32'hD001 || fx_retire !== 32'd9) begin
      fails++; $display("FAIL stall_rel1 got ch=%0d data=%h retire=%0d want 0/d001/9", fx_wb_ch, fx_wb_req.data, fx_retire);
    end
    tick();
    tests++; if (fx_wb_ch !== 1'b1 || fx_wb_req.data !== 32'hC002 || fx_retire !== 32'd10) begin
      fails++; $display("FAIL stall_rel2 got ch=%0d data=%h retire=%0d want 1/c002/10", fx_wb_ch, fx_wb_req.data, fx_retire);
    end
    tick();
    tests++; if (fx_wb_valid !== 1'b0 || fx_retire !== 32'd10) begin
      fails++; $display("FAIL stall_end got v=%b retire=%0d want 0/10", fx_wb_valid, fx_retire);
    end
  endtask

  task automatic test_flush;
    fx_in_valid  = 2'b11;
    fx_in_req[0] = mk(32'h600, 5'd9, 32'hE001);
    fx_in_req[1] = mk(32'h700, 5'd10, 32'hF001);
    tick();
    fx_flush     = 1'b1;
    fx_in_valid  = 2'b01;
    fx_in_req[0] = mk(32'h604, 5'd9, 32'hE002);
    tick();
    fx_flush    = 1'b0;
    fx_in_valid = 2'b00;
    tests++; if (fx_wb_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", fx_wb_valid); end
    tests++; if (fx_in_ready !== 2'b11) begin fails++; $display("FAIL flush_ready got %b want 11", fx_in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (fx_wb_valid !== 1'b0 || fx_retire !== 32'd10) begin
        fails++; $display("FAIL flush_empty%0d got v=%b data=%h retire=%0d want 0/-/10", i, fx_wb_valid, fx_wb_req.data, fx_retire);
      end
    end
  endtask

  task automatic test_round_robin;
    rr_stall    = 1'b1;
    rr_in_valid = 3'b111;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) rr_in_req[c] = mk(32'h800 + 32'(c * 16 + k), 5'(c + 1), 32'h3000 + 32'(c * 16 + k));
      tick();
    end
    rr_in_valid = 3'b000;
    tests++; if (rr_in_ready !== 3'b000) begin fails++; $display("FAIL rr_full got %b want 000", rr_in_ready); end
    rr_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (rr_wb_valid !== 1'b1 || rr_wb_ch !== 2'(i % 3) || rr_wb_req.data !== 32'h3000 + 32'((i % 3) * 16 + i / 3)
          || rr_retire !== 32'(i + 1)) begin
        fails++;
        $display("FAIL rr_seq%0d got v=%b ch=%0d data=%h retire=%0d want 1/%0d/%h/%0d", i, rr_wb_valid, rr_wb_ch,
                 rr_wb_req.data, rr_retire, i % 3, 32'h3000 + 32'((i % 3) * 16 + i / 3), i + 1);
      end
    end
    tick();
    tests++; if (rr_wb_valid !== 1'b0 || rr_retire !== 32'd6) begin
      fails++; $display("FAIL rr_end got v=%b retire=%0d want 0/6", rr_wb_valid, rr_retire);
    end
  endtask

  task automatic test_reset_mid;
    rr_in_valid  = 3'b010;
    rr_in_req[1] = mk(32'h900, 5'd4, 32'h5001);
    tick();
    rr_in_valid = 3'b000;
    tick();
    tests++; if (rr_wb_ch !== 2'd1 || rr_retire !== 32'd7) begin
      fails++; $display("FAIL rmid_pre got ch=%0d retire=%0d want 1/7", rr_wb_ch, rr_retire);
    end
    rr_stall    = 1'b1;
    rr_in_valid = 3'b111;
    for (int c = 0; c < 3; c++) rr_in_req[c] = mk(32'hA00, 5'd2, 32'h5100 + 32'(c));
    tick();
    tick();
    tests++; if (rr_in_ready !== 3'b000) begin fails++; $display("FAIL rmid_full got %b want 000", rr_in_ready); end
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    rr_stall    = 1'b0;
    rr_in_valid = 3'b000;
    tests++; if (rr_wb_valid !== 1'b0 || rr_wb_req !== '0 || rr_wb_ch !== 2'd0 || rr_retire !== 32'd0) begin
      fails++; $display("FAIL rmid_out got v=%b req=%h ch=%0d retire=%0d want 0/0/0/0", rr_wb_valid, rr_wb_req, rr_wb_ch, rr_retire);
    end
    tests++; if (rr_in_ready !== 3'b111) begin fails++; $display("FAIL rmid_ready got %b want 111", rr_in_ready); end
    rr_in_valid  = 3'b101;
    rr_in_req[0] = mk(32'hB00, 5'd1, 32'h6000);
    rr_in_req[2] = mk(32'hB08, 5'd1, 32'h6002);
    tick();
    rr_in_valid = 3'b000;
    tests++; if (rr_wb_valid !== 1'b0) begin fails++; $display("FAIL rmid_idle got %b want 0", rr_wb_valid); end
    tick();
    tests++; if (rr_wb_ch !== 2'd0 || rr_wb_req.data !== 32'h6000) begin
      fails++; $display("FAIL rmid_first got ch=%0d data=%h want 0/6000", rr_wb_ch, rr_wb_req.data);
    end
    tick();
    tests++; if (rr_wb_ch !== 2'd2 || rr_wb_req.data !== 32'h6002 || rr_retire !== 32'd2) begin
      fails++; $display("FAIL rmid_second got ch=%0d data=%h retire=%0d want 2/6002/2", rr_wb_ch, rr_wb_req.data, rr_retire);
    end
  endtask

  initial begin
    reset       = 1'b1;
    fx_in_valid = '0; fx_in_req = '0; fx_stall = 1'b0; fx_flush = 1'b0;
    rr_in_valid = '0; rr_in_req = '0; rr_stall = 1'b0; rr_flush = 1'b0;
    test_reset();
    test_latency();
    test_fixed_priority();
    test_stall();
    test_flush();
    test_round_robin();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout: tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
